// File: rtl/mdu_unit.sv
// -----------------------------------------------------------------------------
// mdu_unit -- multicycle multiply/divide unit with hi/lo write-back
//
// Multiplies and divides run for a fixed number of busy cycles (MULT_LAT or
// DIV_LAT). The hi/lo write strobes pulse in the last busy cycle (DONE).
// mthi/mtlo bypass the FSM and write one register in the cycle after accept.
//
// Optional feature: define MDU_MADD_EN to enable madd/msub (ops 6/7), which
// accumulate a signed product onto {hi_in, lo_in} sampled at accept. Without
// the macro, ops 6/7 are ignored and hi_in/lo_in are unused.
//
// Ports:
//   clk              clock, all state updates on posedge
//   reset            asynchronous active-low reset
//   start            operation request, sampled on posedge (ignored while busy)
//   op[2:0]          0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo, 6 madd, 7 msub
//   rs_data[31:0]    first operand / dividend / mthi-mtlo source
//   rt_data[31:0]    second operand / divisor
//   hi_in, lo_in     current architectural hi/lo (madd/msub accumulator)
//   busy             multiply/divide in progress
//   hiwrite, lowrite single-cycle write strobes
//   hidata, lodata   write values; hold their last value between strobes
// -----------------------------------------------------------------------------
module mdu_unit #(
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic [31:0] hi_in,
  input  logic [31:0] lo_in,
  output logic        busy,
  output logic        hiwrite,
  output logic        lowrite,
  output logic [31:0] hidata,
  output logic [31:0] lodata
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;
`ifdef MDU_MADD_EN
  localparam logic [2:0] OP_MADD  = 3'd6;
  localparam logic [2:0] OP_MSUB  = 3'd7;
`endif

  // Counter is loaded with LAT-1: RUN lasts LAT-1 cycles, DONE one more.
  localparam logic [4:0] MULT_LOAD = 5'(MULT_LAT - 1);
  localparam logic [4:0] DIV_LOAD  = 5'(DIV_LAT - 1);

  state_t      state, state_nxt;
  logic [4:0]  cnt;
  logic [31:0] a_q, b_q;
  logic [2:0]  op_q;

  logic        is_long, is_move, accept_long, accept_move;
  logic [4:0]  load_val;

  logic [31:0] src_a, src_b;
  logic [2:0]  src_op;
  logic [63:0] src_acc;
  logic signed [63:0] prod_s;
  logic [63:0] prod_u;
  logic signed [31:0] quo_s, rem_s;
  logic [63:0] res;

`ifdef MDU_MADD_EN
  logic [63:0] acc_q;
  assign is_long = (op inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MADD, OP_MSUB});
`else
  // hi_in/lo_in have no function in this build.
  logic unused_acc_in;
  assign unused_acc_in = ^{hi_in, lo_in};
  assign is_long = (op inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU});
`endif

  assign is_move     = (op == OP_MTHI) || (op == OP_MTLO);
  assign accept_long = start && (state == IDLE) && is_long;
  assign accept_move = start && (state == IDLE) && is_move;
  assign load_val    = (op == OP_DIV || op == OP_DIVU) ? DIV_LOAD : MULT_LOAD;
  assign busy        = (state != IDLE);

  // In IDLE the only path into DONE is a LAT=1 accept, whose operands are
  // still on the inputs; otherwise the latched copies are used.
  assign src_a  = (state == IDLE) ? rs_data : a_q;
  assign src_b  = (state == IDLE) ? rt_data : b_q;
  assign src_op = (state == IDLE) ? op      : op_q;
`ifdef MDU_MADD_EN
  assign src_acc = (state == IDLE) ? {hi_in, lo_in} : acc_q;
`else
  assign src_acc = 64'd0;
`endif

  // NOTE: state and data registers use non-blocking assignments so every
  // flop samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: every always_comb output is given a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept_long) state_nxt = (load_val == 5'd0) ? DONE : RUN;
      RUN:  if (cnt <= 5'd1) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt  <= 5'd0;
      a_q  <= 32'd0;
      b_q  <= 32'd0;
      op_q <= 3'd0;
`ifdef MDU_MADD_EN
      acc_q <= 64'd0;
`endif
    end else if (accept_long) begin
      cnt  <= load_val;
      a_q  <= rs_data;
      b_q  <= rt_data;
      op_q <= op;
`ifdef MDU_MADD_EN
      acc_q <= {hi_in, lo_in};
`endif
    end else if (state == RUN && cnt != 5'd0) begin
      cnt <= cnt - 5'd1;
    end
  end

  always_comb begin
    prod_s = $signed({{32{src_a[31]}}, src_a}) * $signed({{32{src_b[31]}}, src_b});
    prod_u = {32'd0, src_a} * {32'd0, src_b};
    quo_s  = $signed(src_a) / $signed(src_b);
    rem_s  = $signed(src_a) % $signed(src_b);
    res    = 64'd0;
    case (src_op)
      OP_MULT:  res = prod_s;
      OP_MULTU: res = prod_u;
      OP_DIV: begin
        // Zero divisor and the single signed overflow case are defined
        // explicitly rather than left to the divider.
        if (src_b == 32'd0)
          res = {src_a, 32'hFFFF_FFFF};
        else if (src_a == 32'h8000_0000 && src_b == 32'hFFFF_FFFF)
          res = {32'd0, 32'h8000_0000};
        else
          res = {rem_s, quo_s};
      end
      OP_DIVU: begin
        if (src_b == 32'd0) res = {src_a, 32'hFFFF_FFFF};
        else                res = {src_a % src_b, src_a / src_b};
      end
`ifdef MDU_MADD_EN
      OP_MADD: res = src_acc + prod_s;
      OP_MSUB: res = src_acc - prod_s;
`endif
      default: res = src_acc;
    endcase
  end

  // Strobes are registered so they line up with DONE (or the cycle after a
  // move accept); the data registers hold between strobes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hiwrite <= 1'b0;
      lowrite <= 1'b0;
      hidata  <= 32'd0;
      lodata  <= 32'd0;
    end else begin
      hiwrite <= 1'b0;
      lowrite <= 1'b0;
      if (state_nxt == DONE) begin
        hiwrite <= 1'b1;
        lowrite <= 1'b1;
        hidata  <= res[63:32];
        lodata  <= res[31:0];
      end else if (accept_move) begin
        if (op == OP_MTHI) begin
          hiwrite <= 1'b1;
          hidata  <= rs_data;
        end else begin
          lowrite <= 1'b1;
          lodata  <= rs_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_mdu_unit.sv
// -----------------------------------------------------------------------------
// tb_mdu_unit -- self-checking bench for mdu_unit (default MULT_LAT/DIV_LAT)
//
// A cycle-timestamp reference model predicts busy, strobes and held data for
// every cycle; directed vectors additionally check hand-computed results,
// latencies and the boundary cases. Honors MDU_MADD_EN like the design.
// -----------------------------------------------------------------------------
module tb_mdu_unit;

  localparam int MULT_LAT = 5;
  localparam int DIV_LAT  = 10;
`ifdef MDU_MADD_EN
  localparam bit MADD = 1'b1;
`else
  localparam bit MADD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] rs_data, rt_data, hi_in, lo_in;
  logic        busy, hiwrite, lowrite;
  logic [31:0] hidata, lodata;

  int n_checks = 0;
  int n_errors = 0;
  bit cmp_en   = 1'b0;

  mdu_unit #(.MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .rs_data(rs_data), .rt_data(rt_data), .hi_in(hi_in), .lo_in(lo_in),
    .busy(busy), .hiwrite(hiwrite), .lowrite(lowrite),
    .hidata(hidata), .lodata(lodata)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_errors++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp_v);
    end
  endtask

  // Architectural result of a multiply/divide-class op, plain 64-bit arithmetic.
  function automatic logic [63:0] model_res(input logic [2:0] o, input logic [31:0] s, t, h, l);
    longint sa, sb, q, m;
    longint unsigned ua, ub, uq, um;
    logic [63:0] r;
    sa = $signed(s);
    sb = $signed(t);
    ua = {32'd0, s};
    ub = {32'd0, t};
    r  = 64'd0;
    case (o)
      3'd0: r = sa * sb;
      3'd1: r = ua * ub;
      3'd2: if (t == 32'd0) r = {s, 32'hFFFF_FFFF};
            else begin q = sa / sb; m = sa % sb; r = {m[31:0], q[31:0]}; end
      3'd3: if (t == 32'd0) r = {s, 32'hFFFF_FFFF};
            else begin uq = ua / ub; um = ua % ub; r = {um[31:0], uq[31:0]}; end
      3'd6: r = {h, l} + sa * sb;
      3'd7: r = {h, l} - sa * sb;
      default: r = 64'd0;
    endcase
    return r;
  endfunction

  // Reference model: an accepted op at edge n keeps busy through cycle
  // n+LAT-1 and writes hi/lo in that last cycle.
  int          edge_n = 0;
  int          end_cyc = -1;
  logic [63:0] pending;
  logic        exp_busy = 0, exp_hiw = 0, exp_low = 0;
  logic [31:0] exp_hid = 0, exp_lod = 0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      end_cyc  = -1;
      exp_busy = 0;
      exp_hiw  = 0;
      exp_low  = 0;
      exp_hid  = 0;
      exp_lod  = 0;
    end else begin
      edge_n++;
      exp_hiw = 0;
      exp_low = 0;
      if (!exp_busy && start) begin
        if (op <= 3'd3 || (MADD && op >= 3'd6)) begin
          pending = model_res(op, rs_data, rt_data, hi_in, lo_in);
          end_cyc = edge_n + ((op == 3'd2 || op == 3'd3) ? DIV_LAT : MULT_LAT) - 1;
        end else if (op == 3'd4) begin
          exp_hiw = 1; exp_hid = rs_data;
        end else if (op == 3'd5) begin
          exp_low = 1; exp_lod = rs_data;
        end
      end
      exp_busy = (end_cyc >= edge_n);
      if (end_cyc == edge_n) begin
        exp_hiw = 1;
        exp_low = 1;
        exp_hid = pending[63:32];
        exp_lod = pending[31:0];
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (cmp_en) begin
      check("model busy",    64'(busy),    64'(exp_busy));
      check("model hiwrite", 64'(hiwrite), 64'(exp_hiw));
      check("model lowrite", 64'(lowrite), 64'(exp_low));
      check("model hidata",  64'(hidata),  64'(exp_hid));
      check("model lodata",  64'(lodata),  64'(exp_lod));
    end
  end

  // Called at a negedge; drives start there so back-to-back issue is exercised.
  task automatic long_op(input string name, input logic [2:0] o, input logic [31:0] s, t, h, l,
                         input int exp_lat, input logic [31:0] exp_hi, exp_lo, input bit poke);
    int lat, strobes, strobe_at;
    logic [31:0] got_hi, got_lo;
    lat = 0; strobes = 0; strobe_at = 0; got_hi = 0; got_lo = 0;
    start = 1; op = o; rs_data = s; rt_data = t; hi_in = h; lo_in = l;
    @(negedge clk);
    // Operands must already be latched; scramble the inputs.
    start = 0; op = 3'($urandom); rs_data = $urandom; rt_data = $urandom;
    hi_in = $urandom; lo_in = $urandom;
    while (busy && lat < 40) begin
      if (hiwrite && lowrite) begin
        strobes++; strobe_at = lat + 1; got_hi = hidata; got_lo = lodata;
      end
      if (poke && lat == 0) begin start = 1; op = 3'd2; rs_data = 32'd100; rt_data = 32'd3; end
      if (poke && lat == 1) start = 0;
      lat++;
      @(negedge clk);
    end
    check({name, " latency"},   64'(lat),       64'(exp_lat));
    check({name, " strobes"},   64'(strobes),   64'd1);
    check({name, " strobe_at"}, 64'(strobe_at), 64'(exp_lat));
    check({name, " hi"},        64'(got_hi),    64'(exp_hi));
    check({name, " lo"},        64'(got_lo),    64'(exp_lo));
  endtask

  task automatic move_op(input string name, input logic [2:0] o, input logic [31:0] v);
    start = 1; op = o; rs_data = v; rt_data = $urandom;
    @(negedge clk);
    start = 0; rs_data = $urandom;
    check({name, " busy"},    64'(busy),    64'd0);
    check({name, " hiwrite"}, 64'(hiwrite), 64'(o == 3'd4));
    check({name, " lowrite"}, 64'(lowrite), 64'(o == 3'd5));
    check({name, " data"},    64'((o == 3'd4) ? hidata : lodata), 64'(v));
  endtask

  task automatic ignored_op(input string name, input logic [2:0] o, input logic [31:0] s, t, h, l);
    bit seen;
    seen = 0;
    start = 1; op = o; rs_data = s; rt_data = t; hi_in = h; lo_in = l;
    @(negedge clk);
    start = 0;
    repeat (6) begin
      if (busy || hiwrite || lowrite) seen = 1;
      @(negedge clk);
    end
    check({name, " ignored"}, 64'(seen), 64'd0);
  endtask

  initial begin
    reset = 0; start = 0; op = 0; rs_data = 0; rt_data = 0; hi_in = 0; lo_in = 0;
    repeat (2) @(negedge clk);
    check("reset busy",    64'(busy),    64'd0);
    check("reset strobes", 64'({hiwrite, lowrite}), 64'd0);
    check("reset data",    {hidata, lodata}, 64'd0);
    reset = 1;
    cmp_en = 1;
    @(negedge clk);

    long_op("mult neg",   3'd0, 32'hFFFF_FFFE, 32'd3, 0, 0, MULT_LAT, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 0);
    long_op("div neg",    3'd2, 32'hFFFF_FFF9, 32'd2, 0, 0, DIV_LAT,  32'hFFFF_FFFF, 32'hFFFF_FFFD, 0);
    long_op("divu by0",   3'd3, 32'd7, 32'd0, 0, 0, DIV_LAT, 32'd7, 32'hFFFF_FFFF, 0);
    long_op("multu max",  3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, MULT_LAT, 32'hFFFF_FFFE, 32'd1, 1);
    long_op("div ovf",    3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, DIV_LAT, 32'd0, 32'h8000_0000, 0);
    long_op("div by0",    3'd2, 32'd100, 32'd0, 0, 0, DIV_LAT, 32'd100, 32'hFFFF_FFFF, 0);
    long_op("div negdiv", 3'd2, 32'd7, 32'hFFFF_FFFE, 0, 0, DIV_LAT, 32'd1, 32'hFFFF_FFFD, 0);
    long_op("mult minsq", 3'd0, 32'h8000_0000, 32'h8000_0000, 0, 0, MULT_LAT, 32'h4000_0000, 32'd0, 0);
    long_op("divu big",   3'd3, 32'hFFFF_FFFF, 32'd10, 0, 0, DIV_LAT, 32'd5, 32'h1999_9999, 0);

    move_op("mthi", 3'd4, 32'h1234_5678);
    move_op("mtlo", 3'd5, 32'h9ABC_DEF0);
    @(negedge clk);

`ifdef MDU_MADD_EN
    long_op("madd carry", 3'd6, 32'd1, 32'd1, 32'd0, 32'hFFFF_FFFF, MULT_LAT, 32'd1, 32'd0, 0);
    long_op("msub under", 3'd7, 32'd2, 32'd3, 32'd0, 32'd5, MULT_LAT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
`else
    ignored_op("madd off", 3'd6, 32'd1, 32'd1, 32'd0, 32'hFFFF_FFFF);
    ignored_op("msub off", 3'd7, 32'd2, 32'd3, 32'd0, 32'd5);
`endif

    // Abort a divide in its 4th busy cycle.
    start = 1; op = 3'd2; rs_data = 32'd1000; rt_data = 32'd7;
    @(negedge clk);
    start = 0;
    repeat (3) @(negedge clk);
    check("abort busy before", 64'(busy), 64'd1);
    reset = 0;
    #1;
    check("abort busy",    64'(busy),    64'd0);
    check("abort hiwrite", 64'(hiwrite), 64'd0);
    check("abort lowrite", 64'(lowrite), 64'd0);
    check("abort hidata",  64'(hidata),  64'd0);
    check("abort lodata",  64'(lodata),  64'd0);
    repeat (2) @(negedge clk);
    reset = 1;
    begin
      bit seen;
      seen = 0;
      repeat (15) begin
        @(negedge clk);
        if (busy || hiwrite || lowrite) seen = 1;
      end
      check("abort no strobe", 64'(seen), 64'd0);
    end

    long_op("mult recover", 3'd0, 32'd3, 32'd4, 0, 0, MULT_LAT, 32'd0, 32'd12, 0);
    repeat (3) @(negedge clk);
    cmp_en = 0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mdu_unit.md
MDU_UNIT -- requirements
Module: mdu_unit

Interface
REQ-001 SHALL have parameter MULT_LAT, default 5: busy cycles for mult/multu (legal range 1..31).
REQ-002 SHALL have parameter DIV_LAT, default 10: busy cycles for div/divu (legal range 1..31).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on posedge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  operation request, sampled on posedge.
REQ-006 SHALL have port op  input  3  operation code: 0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo, 6 madd, 7 msub.
REQ-007 SHALL have port rs_data  input  32  first operand / dividend / mthi-mtlo source.
REQ-008 SHALL have port rt_data  input  32  second operand / divisor.
REQ-009 SHALL have port hi_in, lo_in  input  32 each  current architectural hi/lo values (bypassed register-file read).
REQ-010 SHALL have port busy  output  1  operation in progress.
REQ-011 SHALL have port hiwrite, lowrite  output  1 each  single-cycle write strobes to hi/lo.
REQ-012 SHALL have port hidata, lodata  output  32 each  values to write; meaningful only while the matching strobe is high.

Function
REQ-013 Start SHALL be accepted only when busy=0; start while busy=1 SHALL be ignored with no state change.
REQ-014 FSM states SHALL be IDLE, RUN, DONE. IDLE->RUN on an accepted mult/div-class op. RUN->DONE when the down-counter reaches 1. DONE->IDLE after one cycle.
REQ-015 Latency: accept at edge E0 -> busy=1 for exactly LAT cycles after E0; in the last of these cycles (DONE) hiwrite=lowrite=1 with results valid; busy=0 in the following cycle.
REQ-016 Operands and op SHALL be latched at accept; later input changes SHALL NOT affect the result.
REQ-017 mult: 64-bit signed product; multu: 64-bit unsigned product; hi=[63:32], lo=[31:0].
REQ-018 div/divu: lo=quotient, hi=remainder; signed quotient truncates toward zero; remainder takes the dividend's sign.
REQ-019 Divisor 0: hi=rs_data, lo=32'hFFFFFFFF for both div and divu; latency unchanged.
REQ-020 Signed overflow 32'h80000000 div 32'hFFFFFFFF: lo=32'h80000000, hi=0.
REQ-021 mthi/mtlo: no busy; in the cycle after accept exactly one strobe (hiwrite or lowrite) SHALL be high, with data = latched rs_data.
REQ-022 Outside DONE and the mthi/mtlo write cycle, hiwrite=lowrite=0; hidata/lodata SHALL hold their last values.
REQ-023 A new start SHALL be accepted in the cycle busy first reads 0 (back-to-back operation).

Reset
REQ-024 reset=0 SHALL immediately force IDLE, counter=0, busy=0, hiwrite=lowrite=0, hidata=lodata=0, independent of clk.
REQ-025 Reset during RUN/DONE SHALL abort the operation; no strobe SHALL be emitted for it after release.

Configuration
REQ-026 Macro MDU_MADD_EN defined: op 6 (madd) SHALL produce {hi,lo} = {hi_in,lo_in} + signed(rs*rt), and op 7 (msub) SHALL produce {hi,lo} = {hi_in,lo_in} - signed(rs*rt), both with MULT_LAT latency, using hi_in/lo_in sampled at accept.
REQ-027 Macro MDU_MADD_EN undefined: ops 6 and 7 SHALL be ignored exactly like start=0, and hi_in/lo_in SHALL be unused.

Verification
REQ-028 mult rs=32'hFFFFFFFE, rt=3 -> busy for 5 cycles; in the 5th cycle hiwrite=lowrite=1, hi=32'hFFFFFFFF, lo=32'hFFFFFFFA.
REQ-029 div rs=-7 (32'hFFFFFFF9), rt=2 -> 10 busy cycles; lo=32'hFFFFFFFD, hi=32'hFFFFFFFF; divu rs=7, rt=0 -> hi=7, lo=32'hFFFFFFFF.
REQ-030 multu rs=rt=32'hFFFFFFFF, then start=1 with div during busy -> div ignored; result hi=32'hFFFFFFFE, lo=1; busy drops after 5 cycles.
REQ-031 mthi rs=32'h12345678 -> next cycle hiwrite=1, lowrite=0, hidata=32'h12345678, busy stays 0.
REQ-032 div accepted, reset pulled low in the 4th busy cycle -> busy, strobes and data all 0 immediately; no strobe after reset release.
REQ-033 With MDU_MADD_EN: hi_in=0, lo_in=32'hFFFFFFFF, madd rs=1, rt=1 -> hi=1, lo=0 after 5 cycles; without the macro the same stimulus -> busy stays 0 and no strobe.
